// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch lap timer: FSM state,
// field limits and the packed time value used live and in the lap FIFO.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

  // Minute field is sized for the largest supported MIN_MAX (63).
  localparam int MIN_W = 6;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [5:0]       sec;
    logic [6:0]       cs;
  } time_t;

  localparam int TIME_W = $bits(time_t);

endpackage

// File: rtl/lap_fifo.sv
// Synchronous FIFO of lap snapshots with full/empty/count.
// Ports: clk, reset (async), clr (sync), push/din, pop/dout, count, full, empty.
module lap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO
  // can accept a simultaneous push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with prescaler, cs/sec/min time, run/pause FSM and lap FIFO.
// Ports: clk, reset, start/stop/clear/lap/lap_rd in; time, wrap, lap head/status out.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int DIV_WIDTH = 17,
  parameter int MIN_MAX   = 59,
  parameter int LAP_DEPTH = 4,
  localparam int MW = $clog2(MIN_MAX + 1),
  localparam int CW = $clog2(LAP_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          lap,
  input  logic          lap_rd,
  output logic          running,
  output logic [6:0]    cs,
  output logic [5:0]    sec,
  output logic [MW-1:0] min,
  output logic          wrap,
  output logic          lap_valid,
  output logic [6:0]    lap_cs,
  output logic [5:0]    lap_sec,
  output logic [MW-1:0] lap_min,
  output logic [CW-1:0] lap_count,
  output logic          lap_overflow
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST =
    DIV_WIDTH'(TICK_DIV - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  time_t                  time_q, time_d;
  logic                   wrap_q, wrap_d;
  logic                   ovf_q, ovf_d;

  logic                   lap_push, lap_pop;
  time_t                  head;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full, fifo_empty;

  // Upper minute bits stay zero; they are only kept for the shared layout.
  logic                   unused_min_bits;
  assign unused_min_bits = ^{time_q.min, head.min};

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSED;
    end else if (start) begin
      if (state_q != RUN) state_d = RUN;
    end
  end

  // Prescaler and mixed-radix time; both hold outside RUN so a
  // resume finishes the partial tick.
  always_comb begin
    div_d  = div_q;
    time_d = time_q;
    wrap_d = 1'b0;
    if (clear) begin
      div_d  = '0;
      time_d = '0;
    end else if (state_q == RUN) begin
      if (div_q != DIV_LAST) begin
        div_d = div_q + DIV_WIDTH'(1);
      end else begin
        div_d = '0;
        if (time_q.cs != 7'(CS_MAX)) begin
          time_d.cs = time_q.cs + 7'd1;
        end else begin
          time_d.cs = '0;
          if (time_q.sec != 6'(SEC_MAX)) begin
            time_d.sec = time_q.sec + 6'd1;
          end else begin
            time_d.sec = '0;
            if (time_q.min != MIN_LAST) begin
              time_d.min = time_q.min + MIN_W'(1);
            end else begin
              time_d.min = '0;
              wrap_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  assign lap_push = lap & ~clear & (state_q != IDLE);
  assign lap_pop  = lap_rd & ~clear;

  // A full FIFO only drops the lap when no pop makes room.
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (lap_push && fifo_full && !lap_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      time_q  <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      time_q  <= time_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .WIDTH (TIME_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .push  (lap_push),
    .pop   (lap_pop),
    .din   (time_q),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign running      = (state_q == RUN);
  assign cs           = time_q.cs;
  assign sec          = time_q.sec;
  assign min          = time_q.min[MW-1:0];
  assign wrap         = wrap_q;
  assign lap_valid    = ~fifo_empty;
  assign lap_cs       = fifo_empty ? '0 : head.cs;
  assign lap_sec      = fifo_empty ? '0 : head.sec;
  assign lap_min      = fifo_empty ? '0 : head.min[MW-1:0];
  assign lap_count    = fifo_count;
  assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Self-checking bench for stopwatch_lap_timer: directed steps plus
// random stimulus against an elapsed-centisecond reference model.
module tb_stopwatch_lap_timer;

  localparam int TD   = 3;
  localparam int DW   = 2;
  localparam int MM   = 1;
  localparam int LD   = 4;
  localparam int MW   = $clog2(MM + 1);
  localparam int CW   = $clog2(LD) + 1;
  localparam int FULL = (MM + 1) * 6000;

  logic          clk = 1'b0;
  logic          reset, start, stop, clear, lap, lap_rd;
  logic          running, wrap, lap_valid, lap_overflow;
  logic [6:0]    cs, lap_cs;
  logic [5:0]    sec, lap_sec;
  logic [MW-1:0] min, lap_min;
  logic [CW-1:0] lap_count;

  int total_n = 0;
  int bad_n   = 0;

  // Reference model: mode 0 idle, 1 running, 2 paused;
  // time held as elapsed centiseconds.
  int m_mode, m_total, m_pre;
  bit m_wrap, m_ovf;
  int m_q[$];
  int wraps_seen;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .TICK_DIV  (TD),
    .DIV_WIDTH (DW),
    .MIN_MAX   (MM),
    .LAP_DEPTH (LD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .lap          (lap),
    .lap_rd       (lap_rd),
    .running      (running),
    .cs           (cs),
    .sec          (sec),
    .min          (min),
    .wrap         (wrap),
    .lap_valid    (lap_valid),
    .lap_cs       (lap_cs),
    .lap_sec      (lap_sec),
    .lap_min      (lap_min),
    .lap_count    (lap_count),
    .lap_overflow (lap_overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    total_n++;
    assert (got === exp) else begin
      bad_n++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_total = 0;
    m_pre   = 0;
    m_wrap  = 0;
    m_ovf   = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit st, sp, cl, lp, rd);
    m_wrap = 0;
    if (cl) begin
      model_reset();
      return;
    end
    if (rd && m_q.size() > 0) m_q.delete(0);
    if (lp && m_mode != 0) begin
      if (m_q.size() < LD) m_q.push_back(m_total);
      else m_ovf = 1;
    end
    if (m_mode == 1) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_total++;
        if (m_total == FULL) begin
          m_total = 0;
          m_wrap  = 1;
        end
      end else begin
        m_pre++;
      end
    end
    if (sp) begin
      if (m_mode == 1) m_mode = 2;
    end else if (st && m_mode != 1) begin
      m_mode = 1;
    end
  endtask

  task automatic check_all();
    check("running", int'(running), int'(m_mode == 1));
    check("cs", int'(cs), m_total % 100);
    check("sec", int'(sec), (m_total / 100) % 60);
    check("min", int'(min), m_total / 6000);
    check("wrap", int'(wrap), int'(m_wrap));
    check("lap_valid", int'(lap_valid), int'(m_q.size() != 0));
    check("lap_count", int'(lap_count), m_q.size());
    check("lap_overflow", int'(lap_overflow), int'(m_ovf));
    if (m_q.size() > 0) begin
      check("lap_cs", int'(lap_cs), m_q[0] % 100);
      check("lap_sec", int'(lap_sec), (m_q[0] / 100) % 60);
      check("lap_min", int'(lap_min), m_q[0] / 6000);
    end
  endtask

  task automatic step(input bit st, sp, cl, lp, rd);
    @(negedge clk);
    start  = st;
    stop   = sp;
    clear  = cl;
    lap    = lp;
    lap_rd = rd;
    @(posedge clk);
    model_edge(st, sp, cl, lp, rd);
    #1;
    if (wrap) wraps_seen++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    clear  = 1'b0;
    lap    = 1'b0;
    lap_rd = 1'b0;
    wraps_seen = 0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Start latency: running right after the start edge,
    // first cs step TD edges later.
    step(1, 0, 0, 0, 0);
    check("lat_running", int'(running), 1);
    idle(TD - 1);
    check("lat_cs0", int'(cs), 0);
    idle(1);
    check("lat_cs1", int'(cs), 1);
    idle(TD);
    check("lat_cs2", int'(cs), 2);

    // Pause with a partial tick, then resume.
    idle(3 * TD);
    check("run_cs5", int'(cs), 5);
    idle(1);
    step(0, 1, 0, 0, 0);
    check("stop_run", int'(running), 0);
    idle(10);
    check("pause_hold", int'(cs), 5);
    step(1, 0, 0, 0, 0);
    check("resume_cs", int'(cs), 5);
    idle(1);
    check("resume_tick", int'(cs), 6);

    // Five laps into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      idle(2);
    end
    check("lap_full_cnt", int'(lap_count), 4);
    check("lap_ovf_set", int'(lap_overflow), 1);

    // Push and pop together while full.
    step(0, 0, 0, 1, 1);
    check("full_pp_cnt", int'(lap_count), 4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    check("drained", int'(lap_valid), 0);
    step(0, 0, 0, 0, 1);

    // Clear mid-run with two stored laps.
    step(0, 0, 0, 1, 0);
    idle(2);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1);
    check("clr_run", int'(running), 0);
    check("clr_cnt", int'(lap_count), 0);
    check("clr_cs", int'(cs), 0);

    // Lap in IDLE is ignored; start+stop together: stop wins.
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(4);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 6, ($urandom % 100) < 3,
           ($urandom % 100) < 1, ($urandom % 100) < 15,
           ($urandom % 100) < 12);
    end

    // Full-scale wrap at MM:59:99.
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    wraps_seen = 0;
    idle(FULL * TD + 4);
    check("wrap_count", wraps_seen, 1);

    // Async reset mid-tick with laps stored.
    step(0, 0, 0, 1, 0);
    idle(2);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
